// File: rtl/branch_predictor_if.sv
// Fetch-side prediction lookup and ID-side resolution feedback between the pipeline and the predictor.
interface branch_predictor_if #(
  parameter int width = 32
);
  logic [width-1:0] IF_pc;
  logic             IF_br_pred;
  logic [width-1:0] IF_pred_target;
  logic             ID_valid;
  logic             ID_stall;
  logic [1:0]       ID_kind;
  logic [width-1:0] ID_pc;
  logic             ID_br_en;
  logic [width-1:0] ID_target;
  logic             ID_br_pred;

  modport master (
    output IF_pc, ID_valid, ID_stall, ID_kind, ID_pc, ID_br_en, ID_target, ID_br_pred,
    input  IF_br_pred, IF_pred_target
  );

  modport slave (
    input  IF_pc, ID_valid, ID_stall, ID_kind, ID_pc, ID_br_en, ID_target, ID_br_pred,
    output IF_br_pred, IF_pred_target
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit BHT plus direct-mapped, fully tagged BTB; trained by ID, with resolved/mispredict counters.
module branch_predictor #(
  parameter int width        = 32,
  parameter int BHT_IDX_BITS = 6,
  parameter int BTB_IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bp,
  output logic                ready_o,
  output logic [31:0]         resolved_cnt_o,
  output logic [31:0]         mispred_cnt_o
);

  localparam int BHT_N      = 1 << BHT_IDX_BITS;
  localparam int BTB_N      = 1 << BTB_IDX_BITS;
  localparam int TAG_W      = width - BTB_IDX_BITS - 2;
  localparam int SWEEP_BITS = (BHT_IDX_BITS > BTB_IDX_BITS) ? BHT_IDX_BITS : BTB_IDX_BITS;

  typedef enum logic {INIT, RUN} state_e;

  state_e                  state_q, state_d;
  logic [SWEEP_BITS-1:0]   ptr_q, ptr_d;
  logic                    running;
  logic                    initWr;

  logic [1:0]              bht_q       [BHT_N];
  logic                    btbValid_q  [BTB_N];
  logic [TAG_W-1:0]        btbTag_q    [BTB_N];
  logic [width-1:0]        btbTarget_q [BTB_N];
  logic                    btbIsJal_q  [BTB_N];

  logic [31:0]             resolved_q, resolved_d;
  logic [31:0]             mispred_q, mispred_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    running = (state_q == RUN);
    initWr  = (state_q == INIT);
    ready_o = running;
  end

  logic [BHT_IDX_BITS-1:0] ifBhtIdx;
  logic [BTB_IDX_BITS-1:0] ifBtbIdx;
  logic [TAG_W-1:0]        ifTag;
  logic                    ifHit;
  logic                    ifPred;

  assign ifBhtIdx = bp.IF_pc[BHT_IDX_BITS+1:2];
  assign ifBtbIdx = bp.IF_pc[BTB_IDX_BITS+1:2];
  assign ifTag    = bp.IF_pc[width-1:BTB_IDX_BITS+2];
  assign ifHit    = btbValid_q[ifBtbIdx] && (btbTag_q[ifBtbIdx] == ifTag);
  // A jalr entry is never written, so a hit is either a br (BHT decides) or a jal (always taken)
  assign ifPred   = running && ifHit && (btbIsJal_q[ifBtbIdx] || bht_q[ifBhtIdx][1]);

  assign bp.IF_br_pred     = ifPred;
  assign bp.IF_pred_target = ifPred ? btbTarget_q[ifBtbIdx] : bp.IF_pc + width'(4);

  logic                    updEn;
  logic                    isBr, isJal, isJalr;
  logic [BHT_IDX_BITS-1:0] idBhtIdx;
  logic [BTB_IDX_BITS-1:0] idBtbIdx;
  logic [TAG_W-1:0]        idTag;
  logic [1:0]              bhtOld, bhtNew;
  logic                    bhtWrEn, btbWrEn;
  logic                    mispredict;
  logic                    unusedIdPcLow;

  assign unusedIdPcLow = ^bp.ID_pc[1:0];

  assign isBr     = (bp.ID_kind == 2'b01);
  assign isJal    = (bp.ID_kind == 2'b10);
  assign isJalr   = (bp.ID_kind == 2'b11);
  assign updEn    = running && bp.ID_valid && !bp.ID_stall && (bp.ID_kind != 2'b00);
  assign idBhtIdx = bp.ID_pc[BHT_IDX_BITS+1:2];
  assign idBtbIdx = bp.ID_pc[BTB_IDX_BITS+1:2];
  assign idTag    = bp.ID_pc[width-1:BTB_IDX_BITS+2];
  assign bhtOld   = bht_q[idBhtIdx];

  always_comb begin
    bhtNew = bhtOld;
    if (bp.ID_br_en) begin
      if (bhtOld != 2'b11) bhtNew = bhtOld + 2'b01;
    end else begin
      if (bhtOld != 2'b00) bhtNew = bhtOld - 2'b01;
    end
  end

  assign bhtWrEn    = updEn && isBr;
  assign btbWrEn    = updEn && ((isBr && bp.ID_br_en) || isJal);
  assign mispredict = (isBr && (bp.ID_br_en != bp.ID_br_pred)) || ((isJal || isJalr) && !bp.ID_br_pred);

  // Table arrays carry no reset; the INIT sweep establishes their contents after every rst
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (initWr) begin
        if ((ptr_q >> BHT_IDX_BITS) == '0) bht_q[ptr_q[BHT_IDX_BITS-1:0]] <= 2'b01;
        if ((ptr_q >> BTB_IDX_BITS) == '0) btbValid_q[ptr_q[BTB_IDX_BITS-1:0]] <= 1'b0;
      end else begin
        if (bhtWrEn) bht_q[idBhtIdx] <= bhtNew;
        if (btbWrEn) begin
          btbValid_q[idBtbIdx]  <= 1'b1;
          btbTag_q[idBtbIdx]    <= idTag;
          btbTarget_q[idBtbIdx] <= bp.ID_target;
          btbIsJal_q[idBtbIdx]  <= isJal;
        end
      end
    end
  end

  always_comb begin
    resolved_d = resolved_q;
    mispred_d  = mispred_q;
    if (updEn && (resolved_q != 32'hFFFF_FFFF)) resolved_d = resolved_q + 32'd1;
    if (updEn && mispredict && (mispred_q != 32'hFFFF_FFFF)) mispred_d = mispred_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      resolved_q <= resolved_d;
      mispred_q  <= mispred_d;
    end
  end

  assign resolved_cnt_o = resolved_q;
  assign mispred_cnt_o  = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge monitor pops and compares.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [31:0] resolvedCnt, mispredCnt;

  branch_predictor_if #(.width(32)) bpIf ();

  branch_predictor #(.width(32), .BHT_IDX_BITS(6), .BTB_IDX_BITS(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .bp             (bpIf.slave),
    .ready_o        (ready),
    .resolved_cnt_o (resolvedCnt),
    .mispred_cnt_o  (mispredCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pred;
    logic [31:0] target;
    logic        rdy;
    logic [31:0] res;
    logic [31:0] mis;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  // Reference model: counters as plain integers, BTB remembers the trained word address
  int          bhtM     [64];
  bit          btbV     [32];
  logic [31:0] btbWord  [32];
  logic [31:0] btbTgt   [32];
  bit          btbJal   [32];
  int          initLeft;
  longint      resM, misM;

  task automatic modelReset();
    initLeft = 64;
    for (int i = 0; i < 64; i++) bhtM[i] = 1;
    for (int i = 0; i < 32; i++) btbV[i] = 1'b0;
    resM = 0;
    misM = 0;
  endtask

  task automatic modelPredict(input logic [31:0] pc, output exp_t e);
    int  ti, bi;
    bit  hit;
    ti       = int'((pc >> 2) % 32);
    bi       = int'((pc >> 2) % 64);
    hit      = btbV[ti] && (btbWord[ti] == (pc >> 2));
    e.rdy    = (initLeft == 0);
    e.pred   = e.rdy && hit && (btbJal[ti] || bhtM[bi] >= 2);
    e.target = e.pred ? btbTgt[ti] : pc + 32'd4;
    e.res    = resM[31:0];
    e.mis    = misM[31:0];
  endtask

  task automatic modelStep(input bit r, input bit v, input bit s, input logic [1:0] k,
                           input logic [31:0] ipc, input bit en, input logic [31:0] tgt,
                           input bit bpred);
    int ti, bi;
    bit mis;
    if (r) begin
      modelReset();
      return;
    end
    if (initLeft > 0) begin
      initLeft--;
      return;
    end
    if (!v || s || k == 2'b00) return;
    ti = int'((ipc >> 2) % 32);
    bi = int'((ipc >> 2) % 64);
    if (k == 2'b01) begin
      bhtM[bi] = en ? ((bhtM[bi] < 3) ? bhtM[bi] + 1 : 3) : ((bhtM[bi] > 0) ? bhtM[bi] - 1 : 0);
      if (en) begin
        btbV[ti] = 1'b1; btbWord[ti] = ipc >> 2; btbTgt[ti] = tgt; btbJal[ti] = 1'b0;
      end
      mis = (en != bpred);
    end else begin
      if (k == 2'b10) begin
        btbV[ti] = 1'b1; btbWord[ti] = ipc >> 2; btbTgt[ti] = tgt; btbJal[ti] = 1'b1;
      end
      mis = !bpred;
    end
    if (resM < 64'hFFFF_FFFF) resM++;
    if (mis && misM < 64'hFFFF_FFFF) misM++;
  endtask

  task automatic applyStimulus(input bit r, input logic [31:0] pc, input bit v, input bit s,
                               input logic [1:0] k, input logic [31:0] ipc, input bit en,
                               input logic [31:0] tgt, input bit bpred);
    exp_t e;
    rst                  = r;
    bpIf.IF_pc           = pc;
    bpIf.ID_valid        = v;
    bpIf.ID_stall        = s;
    bpIf.ID_kind         = k;
    bpIf.ID_pc           = ipc;
    bpIf.ID_br_en        = en;
    bpIf.ID_target       = tgt;
    bpIf.ID_br_pred      = bpred;
    modelPredict(pc, e);
    expQ.push_back(e);
    @(posedge clk);
    modelStep(r, v, s, k, ipc, en, tgt, bpred);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, pc, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("pred",     {31'b0, bpIf.IF_br_pred}, {31'b0, e.pred});
      checkOutput("target",   bpIf.IF_pred_target,      e.target);
      checkOutput("ready",    {31'b0, ready},           {31'b0, e.rdy});
      checkOutput("resolved", resolvedCnt,              e.res);
      checkOutput("mispred",  mispredCnt,               e.mis);
    end
  end

  function automatic logic [31:0] randPc();
    logic [31:0] pc;
    pc = ($urandom_range(0, 1) == 1) ? 32'h0000_1000 : 32'h0000_0000;
    pc = pc + 32'($urandom_range(0, 15)) * 32'd4;
    if ($urandom_range(0, 15) == 0) pc = pc + 32'($urandom_range(1, 3));
    return pc;
  endfunction

  initial begin
    logic [31:0] ipc;
    logic [1:0]  k;
    bit          en, r;

    rst = 1'b1;
    bpIf.IF_pc = 32'h60; bpIf.ID_valid = 1'b0; bpIf.ID_stall = 1'b0; bpIf.ID_kind = 2'b00;
    bpIf.ID_pc = 32'h0;  bpIf.ID_br_en = 1'b0; bpIf.ID_target = 32'h0; bpIf.ID_br_pred = 1'b0;
    @(posedge clk);
    modelReset();
    #1;

    idle(32'h60, 66);

    // Two taken br @0x80 predicted not-taken, then lookup
    repeat (2) applyStimulus(1'b0, 32'h60, 1'b1, 1'b0, 2'b01, 32'h80, 1'b1, 32'h40, 1'b0);
    idle(32'h80, 2);

    repeat (4) applyStimulus(1'b0, 32'h80, 1'b1, 1'b0, 2'b01, 32'h80, 1'b0, 32'h40, 1'b0);
    idle(32'h80, 2);

    // jal trained while IF looks up the same PC
    applyStimulus(1'b0, 32'h100, 1'b1, 1'b0, 2'b10, 32'h100, 1'b1, 32'h200, 1'b0);
    idle(32'h100, 2);

    repeat (3) applyStimulus(1'b0, 32'h120, 1'b1, 1'b0, 2'b11, 32'h120, 1'b1, 32'h300, 1'b0);
    idle(32'h120, 2);

    repeat (3) applyStimulus(1'b0, 32'h80, 1'b1, 1'b1, 2'b01, 32'h80, 1'b1, 32'h44, 1'b0);
    applyStimulus(1'b0, 32'h80, 1'b1, 1'b0, 2'b01, 32'h80, 1'b1, 32'h44, 1'b0);
    idle(32'h80, 2);

    // Reset in the middle of the INIT sweep
    applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(32'h60, 20);
    applyStimulus(1'b1, 32'h60, 1'b1, 1'b0, 2'b01, 32'h80, 1'b1, 32'h40, 1'b0);
    idle(32'h60, 66);

    for (int i = 0; i < 3000; i++) begin
      ipc = randPc();
      k   = 2'($urandom_range(0, 3));
      en  = (k == 2'b01) ? bit'($urandom_range(0, 1)) : 1'b1;
      r   = ($urandom_range(0, 599) == 0);
      applyStimulus(r, randPc(), bit'($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), k,
                    ipc, en, {16'h0, 14'($urandom), 2'b00}, bit'($urandom_range(0, 1)));
    end
    idle(32'h80, 2);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
